// File: rtl/rename_regfile.sv
// rename_regfile
//   Architectural register file with per-register rename tags and per-branch
//   checkpoints of the tag table.
//
//   Ports
//     clk, rst           clock; asynchronous active-high reset
//     rdy                global enable; state holds while low
//     enCom/comTag/comData   ROB commit: value for every register still
//                            tagged with comTag
//     readAddrO/T        operand register indices
//     readDataO/T        operand values (combinational, with commit bypass)
//     readTagO/T         pending producer tag, or TAG_FREE
//     renameEn/Addr/Tag  stamp a destination register with its ROB tag
//     bNewEn/bNewNum     snapshot the tag table into a checkpoint slot
//     bFreeEn/bFreeNum   branch resolved; misTaken restores that slot
module rename_regfile #(
   parameter int                REG_NUM  = 32,
   parameter int                DATA_W   = 32,
   parameter int                TAG_W    = 4,
   parameter logic [TAG_W-1:0]  TAG_FREE = 4'b1000,
   parameter int                BR_NUM   = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rdy,
   input  logic                      enCom,
   input  logic [TAG_W-1:0]          comTag,
   input  logic [DATA_W-1:0]         comData,
   input  logic [4:0]                readAddrO,
   input  logic [4:0]                readAddrT,
   output logic [DATA_W-1:0]         readDataO,
   output logic [TAG_W-1:0]          readTagO,
   output logic [DATA_W-1:0]         readDataT,
   output logic [TAG_W-1:0]          readTagT,
   input  logic                      renameEn,
   input  logic [4:0]                renameAddr,
   input  logic [TAG_W-1:0]          renameTag,
   input  logic                      bNewEn,
   input  logic [$clog2(BR_NUM)-1:0] bNewNum,
   input  logic                      bFreeEn,
   input  logic [$clog2(BR_NUM)-1:0] bFreeNum,
   input  logic                      misTaken
);

   localparam int BW = $clog2(BR_NUM);

   logic [DATA_W-1:0] data_q [REG_NUM];
   logic [TAG_W-1:0]  tag_q  [REG_NUM];
   logic [TAG_W-1:0]  ckpt_q [BR_NUM][REG_NUM];

   // Per-register next-state; x0 is never written so only 1..REG_NUM-1 exist.
   logic [TAG_W-1:0]  base     [1:REG_NUM-1];
   logic [TAG_W-1:0]  tag_nxt  [1:REG_NUM-1];
   logic              hit      [1:REG_NUM-1];

   logic mis, com_vld, ren, bnew;

   // A mispredict flushes the dispatcher: its rename and checkpoint requests
   // in the same cycle belong to squashed instructions.
   assign mis     = bFreeEn & misTaken;
   assign com_vld = enCom & (comTag != TAG_FREE);
   assign ren     = renameEn & ~mis & (renameAddr != 5'd0);
   assign bnew    = bNewEn & ~mis;

   // Table update order: pick the base table (live or restored checkpoint),
   // apply the commit clear, then the rename on top so a rename beats a
   // same-cycle commit of the register's previous producer.
   for (genvar r = 1; r < REG_NUM; r++) begin : g_reg
      assign base[r]    = mis ? ckpt_q[bFreeNum][r] : tag_q[r];
      assign hit[r]     = com_vld & (base[r] == comTag);
      assign tag_nxt[r] = (ren && renameAddr == 5'(r)) ? renameTag :
                          hit[r]                        ? TAG_FREE  : base[r];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < REG_NUM; r++) begin
            data_q[r] <= '0;
            tag_q[r]  <= TAG_FREE;
         end
      end else if (rdy) begin
         for (int r = 1; r < REG_NUM; r++) begin
            tag_q[r] <= tag_nxt[r];
            if (hit[r]) data_q[r] <= comData;
         end
      end
   end

   // Checkpoints track commits too, so a later restore never resurrects a
   // tag whose value has already landed in the data array.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < BR_NUM; b++)
            for (int r = 0; r < REG_NUM; r++)
               ckpt_q[b][r] <= TAG_FREE;
      end else if (rdy) begin
         for (int b = 0; b < BR_NUM; b++) begin
            for (int r = 1; r < REG_NUM; r++) begin
               if (bnew && bNewNum == BW'(b))
                  ckpt_q[b][r] <= tag_nxt[r];
               else if (com_vld && ckpt_q[b][r] == comTag)
                  ckpt_q[b][r] <= TAG_FREE;
            end
         end
      end
   end

   // Read ports see pre-edge state, plus the value committing this cycle.
   function automatic logic byp(input logic [TAG_W-1:0] t, input logic en,
                                input logic [TAG_W-1:0] ct);
      return en && (t != TAG_FREE) && (t == ct);
   endfunction

   always_comb begin
      readDataO = data_q[readAddrO];
      readTagO  = tag_q[readAddrO];
      if (readAddrO == 5'd0) begin
         readDataO = '0;
         readTagO  = TAG_FREE;
      end else if (byp(tag_q[readAddrO], enCom, comTag)) begin
         readDataO = comData;
         readTagO  = TAG_FREE;
      end
   end

   always_comb begin
      readDataT = data_q[readAddrT];
      readTagT  = tag_q[readAddrT];
      if (readAddrT == 5'd0) begin
         readDataT = '0;
         readTagT  = TAG_FREE;
      end else if (byp(tag_q[readAddrT], enCom, comTag)) begin
         readDataT = comData;
         readTagT  = TAG_FREE;
      end
   end

endmodule

// File: tb/tb_rename_regfile.sv
module tb_rename_regfile;

   localparam logic [3:0] FREE = 4'b1000;

   logic        clk = 1'b0;
   logic        rst, rdy, enCom, renameEn, bNewEn, bFreeEn, misTaken;
   logic [3:0]  comTag, renameTag, readTagO, readTagT;
   logic [31:0] comData, readDataO, readDataT;
   logic [4:0]  readAddrO, readAddrT, renameAddr;
   logic [1:0]  bNewNum, bFreeNum;

   int errors = 0;
   int checks = 0;
   string cur = "";

   typedef struct packed {
      logic        port;
      logic [4:0]  addr;
      logic [31:0] d;
      logic [3:0]  t;
   } exp_t;
   exp_t sb[$];

   rename_regfile dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .enCom(enCom), .comTag(comTag), .comData(comData),
      .readAddrO(readAddrO), .readAddrT(readAddrT),
      .readDataO(readDataO), .readTagO(readTagO),
      .readDataT(readDataT), .readTagT(readTagT),
      .renameEn(renameEn), .renameAddr(renameAddr), .renameTag(renameTag),
      .bNewEn(bNewEn), .bNewNum(bNewNum),
      .bFreeEn(bFreeEn), .bFreeNum(bFreeNum), .misTaken(misTaken)
   );

   always #5 clk = ~clk;

   task automatic idle();
      enCom = 0; comTag = 0; comData = 0;
      renameEn = 0; renameAddr = 0; renameTag = 0;
      bNewEn = 0; bNewNum = 0; bFreeEn = 0; bFreeNum = 0; misTaken = 0;
   endtask

   // Apply current inputs at the next edge, then stand just past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_rd(input string nm,
                            input logic [4:0] ao, input logic [31:0] dob, input logic [3:0] tob,
                            input logic [4:0] at, input logic [31:0] dt, input logic [3:0] tt);
      cur = nm;
      readAddrO = ao;
      readAddrT = at;
      sb.push_back('{port: 1'b0, addr: ao, d: dob, t: tob});
      sb.push_back('{port: 1'b1, addr: at, d: dt, t: tt});
   endtask

   task automatic check_now();
      exp_t e;
      logic [31:0] od;
      logic [3:0]  ot;
      while (sb.size() > 0) begin
         e  = sb.pop_front();
         od = e.port ? readDataT : readDataO;
         ot = e.port ? readTagT  : readTagO;
         checks++;
         assert (od === e.d) else begin
            errors++;
            $error("FAIL %s data x%0d port%0d: got %h expected %h", cur, e.addr, e.port, od, e.d);
         end
         checks++;
         assert (ot === e.t) else begin
            errors++;
            $error("FAIL %s tag x%0d port%0d: got %h expected %h", cur, e.addr, e.port, ot, e.t);
         end
      end
   endtask

   // Combinational reads are sampled mid-cycle, away from the active edge.
   task automatic sample();
      @(negedge clk);
      check_now();
   endtask

   initial begin
      rst = 1; rdy = 1; readAddrO = 0; readAddrT = 0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      expect_rd("reset", 5'd5, 32'h0, FREE, 5'd0, 32'h0, FREE);
      sample();
      step();
      rst = 0;

      // rename then read, commit bypass, then stored value
      renameEn = 1; renameAddr = 3; renameTag = 4'd2;
      step(); idle();
      expect_rd("rename_x3", 5'd3, 32'h0, 4'd2, 5'd3, 32'h0, 4'd2);
      sample(); step();
      enCom = 1; comTag = 4'd2; comData = 32'hDEADBEEF;
      expect_rd("bypass_x3", 5'd3, 32'hDEADBEEF, FREE, 5'd3, 32'hDEADBEEF, FREE);
      sample(); step(); idle();
      expect_rd("stored_x3", 5'd3, 32'hDEADBEEF, FREE, 5'd0, 32'h0, FREE);
      sample(); step();

      // one commit retires two registers sharing a tag
      renameEn = 1; renameAddr = 4; renameTag = 4'd1;
      step();
      renameAddr = 6;
      step(); idle();
      expect_rd("pend_x4x6", 5'd4, 32'h0, 4'd1, 5'd6, 32'h0, 4'd1);
      sample(); step();
      enCom = 1; comTag = 4'd1; comData = 32'h55;
      step(); idle();
      expect_rd("multi_commit", 5'd4, 32'h55, FREE, 5'd6, 32'h55, FREE);
      sample(); step();

      // checkpoint includes the branch's own rename; mispredict restores it
      renameEn = 1; renameAddr = 7; renameTag = 4'd3; bNewEn = 1; bNewNum = 1;
      step(); idle();
      renameEn = 1; renameAddr = 7; renameTag = 4'd4;
      step(); idle();
      expect_rd("x7_tag4", 5'd7, 32'h0, 4'd4, 5'd7, 32'h0, 4'd4);
      sample(); step();
      bFreeEn = 1; bFreeNum = 1; misTaken = 1;
      renameEn = 1; renameAddr = 10; renameTag = 4'd6;   // flushed
      step(); idle();
      expect_rd("restore_x7", 5'd7, 32'h0, 4'd3, 5'd10, 32'h0, FREE);
      sample(); step();
      renameEn = 1; renameAddr = 7; renameTag = 4'd4;
      step(); idle();
      bFreeEn = 1; bFreeNum = 1; misTaken = 1;
      enCom = 1; comTag = 4'd3; comData = 32'h777;
      expect_rd("pre_restore_x7", 5'd7, 32'h0, 4'd4, 5'd0, 32'h0, FREE);
      sample(); step(); idle();
      expect_rd("restore_commit_x7", 5'd7, 32'h777, FREE, 5'd7, 32'h777, FREE);
      sample(); step();

      // commit after checkpoint: stale tag must not come back
      renameEn = 1; renameAddr = 8; renameTag = 4'd5; bNewEn = 1; bNewNum = 0;
      step(); idle();
      enCom = 1; comTag = 4'd5; comData = 32'h88;
      step(); idle();
      bFreeEn = 1; bFreeNum = 0; misTaken = 1;
      step(); idle();
      expect_rd("no_stale_x8", 5'd8, 32'h88, FREE, 5'd8, 32'h88, FREE);
      sample(); step();

      // x0 ignores rename; rdy low freezes state
      renameEn = 1; renameAddr = 0; renameTag = 4'd6;
      step(); idle();
      rdy = 0; renameEn = 1; renameAddr = 9; renameTag = 4'd6;
      step(); idle(); rdy = 1;
      expect_rd("x0_and_rdy", 5'd0, 32'h0, FREE, 5'd9, 32'h0, FREE);
      sample(); step();

      // correct prediction: resolve leaves the live table alone
      renameEn = 1; renameAddr = 11; renameTag = 4'd2; bNewEn = 1; bNewNum = 2;
      step(); idle();
      renameEn = 1; renameAddr = 11; renameTag = 4'd5;
      bFreeEn = 1; bFreeNum = 2; misTaken = 0;
      step(); idle();
      expect_rd("good_resolve", 5'd11, 32'h0, 4'd5, 5'd7, 32'h777, FREE);
      sample(); step();

      // asynchronous reset mid-operation
      renameEn = 1; renameAddr = 12; renameTag = 4'd3;
      step(); idle();
      expect_rd("pre_reset_x12", 5'd12, 32'h0, 4'd3, 5'd3, 32'hDEADBEEF, FREE);
      sample();
      #2 rst = 1;
      #1;
      expect_rd("async_reset", 5'd12, 32'h0, FREE, 5'd3, 32'h0, FREE);
      check_now();
      step();
      rst = 0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
